// File: rtl/rx_symbol_align_ctrl.sv
// Rx-lane symbol alignment: hunts for K28.5 in the serial stream, confirms the
// boundary over several commas, then delivers aligned 10-bit symbols.
module rx_symbol_align_ctrl #(
  parameter int unsigned LOCK_COMMAS    = 3,
  parameter int unsigned MISALIGN_LIMIT = 4,
  parameter int unsigned TIMEOUT_SYMS   = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_in,
  input  logic       bit_en,
  output logic [9:0] symbol_out,
  output logic       symbol_valid,
  output logic       symbol_is_comma,
  output logic       locked,
  output logic [1:0] align_state,
  output logic       lock_lost
);

  localparam int unsigned CW = $clog2(LOCK_COMMAS + 1);
  localparam int unsigned MW = $clog2(MISALIGN_LIMIT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_SYMS + 1);

  localparam logic [CW-1:0] LockCnt  = CW'(LOCK_COMMAS);
  localparam logic [MW-1:0] MisCnt   = MW'(MISALIGN_LIMIT);
  localparam logic [TW-1:0] TmoCnt   = TW'(TIMEOUT_SYMS);
  localparam logic [9:0]    CommaNeg = 10'b0011111010;
  localparam logic [9:0]    CommaPos = 10'b1100000101;

  typedef enum logic [1:0] {StHunt = 2'd0, StCheck = 2'd1, StLocked = 2'd2} state_e;

  state_e        state_q, state_d;
  logic [9:0]    win_q, nxt_win;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] comma_cnt_q, comma_cnt_d, comma_inc;
  logic [MW-1:0] mis_cnt_q, mis_cnt_d, mis_inc;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d, tmo_inc;
  logic [9:0]    sym_q, sym_d;
  logic          valid_q, valid_d;
  logic          is_comma_q, is_comma_d;
  logic          lost_q, lost_d;
  logic          is_comma, boundary;

  assign nxt_win  = {win_q[8:0], data_in};
  assign is_comma = (nxt_win == CommaNeg) || (nxt_win == CommaPos);
  assign boundary = (bit_cnt_q == 4'd9);

  // Saturating increments; counters never wrap
  assign comma_inc = (comma_cnt_q == LockCnt) ? comma_cnt_q : comma_cnt_q + CW'(1);
  assign mis_inc   = (mis_cnt_q == MisCnt) ? mis_cnt_q : mis_cnt_q + MW'(1);
  assign tmo_inc   = (tmo_cnt_q == TmoCnt) ? tmo_cnt_q : tmo_cnt_q + TW'(1);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    comma_cnt_d = comma_cnt_q;
    mis_cnt_d   = mis_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    sym_d       = sym_q;
    is_comma_d  = is_comma_q;
    valid_d     = 1'b0;
    lost_d      = 1'b0;

    if (bit_en) begin
      bit_cnt_d = boundary ? 4'd0 : bit_cnt_q + 4'd1;
      unique case (state_q)
        StHunt: begin
          if (is_comma) begin
            bit_cnt_d   = 4'd0;
            comma_cnt_d = CW'(1);
            tmo_cnt_d   = '0;
            state_d     = StCheck;
          end
        end
        StCheck: begin
          if (is_comma && boundary) begin
            comma_cnt_d = comma_inc;
            tmo_cnt_d   = '0;
            if (comma_inc == LockCnt) begin
              state_d    = StLocked;
              mis_cnt_d  = '0;
              sym_d      = nxt_win;
              valid_d    = 1'b1;
              is_comma_d = 1'b1;
            end
          end else if (is_comma) begin
            // Realign onto the new comma without dropping back to hunt
            bit_cnt_d   = 4'd0;
            comma_cnt_d = CW'(1);
            tmo_cnt_d   = '0;
          end else if (boundary) begin
            tmo_cnt_d = tmo_inc;
            if (tmo_inc == TmoCnt) begin
              state_d = StHunt;
            end
          end
        end
        StLocked: begin
          if (boundary) begin
            sym_d      = nxt_win;
            valid_d    = 1'b1;
            is_comma_d = is_comma;
          end
          if (is_comma && boundary) begin
            mis_cnt_d = '0;
          end else if (is_comma) begin
            mis_cnt_d = mis_inc;
            if (mis_inc == MisCnt) begin
              state_d     = StHunt;
              lost_d      = 1'b1;
              comma_cnt_d = '0;
              mis_cnt_d   = '0;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StHunt;
      win_q       <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      mis_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      sym_q       <= '0;
      valid_q     <= 1'b0;
      is_comma_q  <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      if (bit_en) begin
        win_q <= nxt_win;
      end
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      mis_cnt_q   <= mis_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      sym_q       <= sym_d;
      valid_q     <= valid_d;
      is_comma_q  <= is_comma_d;
      lost_q      <= lost_d;
    end
  end

  assign symbol_out      = sym_q;
  assign symbol_valid    = valid_q;
  assign symbol_is_comma = is_comma_q;
  assign locked          = (state_q == StLocked);
  assign align_state     = state_q;
  assign lock_lost       = lost_q;

endmodule

// File: tb/tb_rx_symbol_align_ctrl.sv
// Self-checking bench for rx_symbol_align_ctrl: directed vector table, bit_en gap and
// reset sequences, and random symbol streams against a bit-history reference model.
module tb_rx_symbol_align_ctrl;

  localparam int         LockCommas    = 3;
  localparam int         MisalignLimit = 4;
  localparam int         TimeoutSyms   = 32;
  localparam logic [9:0] KNeg          = 10'h0FA;
  localparam logic [9:0] KPos          = 10'h305;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       data_in = 1'b0;
  logic       bit_en = 1'b0;
  logic [9:0] symbol_out;
  logic       symbol_valid;
  logic       symbol_is_comma;
  logic       locked;
  logic [1:0] align_state;
  logic       lock_lost;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rx_symbol_align_ctrl #(
    .LOCK_COMMAS   (LockCommas),
    .MISALIGN_LIMIT(MisalignLimit),
    .TIMEOUT_SYMS  (TimeoutSyms)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in        (data_in),
    .bit_en         (bit_en),
    .symbol_out     (symbol_out),
    .symbol_valid   (symbol_valid),
    .symbol_is_comma(symbol_is_comma),
    .locked         (locked),
    .align_state    (align_state),
    .lock_lost      (lock_lost)
  );

  int    vectors = 0;
  int    miscompares = 0;
  string phase = "init";
  int    prev_valid_cyc = 0;
  int    last_valid_cyc = 0;

  // Reference model: full accepted-bit history, boundary = multiple of 10 bits past anchor
  logic       hist[$];
  int         m_state, m_anchor, m_commas, m_mis, m_tmo;
  logic [9:0] e_out;
  logic       e_valid, e_comma, e_lost;

  task automatic model_reset();
    hist.delete();
    m_state = 0; m_anchor = 0; m_commas = 0; m_mis = 0; m_tmo = 0;
    e_out = '0; e_valid = 0; e_comma = 0; e_lost = 0;
  endtask

  task automatic model_step(input logic b, input logic en);
    logic [9:0] w;
    logic       cm, bnd;
    int         n;
    e_valid = 0;
    e_lost  = 0;
    if (!en) return;
    hist.push_back(b);
    n = hist.size();
    for (int k = 0; k < 10; k++) w[9-k] = (n - 10 + k >= 0) ? hist[n-10+k] : 1'b0;
    cm  = (w == KNeg) || (w == KPos);
    bnd = ((n - m_anchor) % 10) == 0;
    case (m_state)
      0: if (cm) begin
        m_anchor = n; m_commas = 1; m_tmo = 0; m_state = 1;
      end
      1: begin
        if (cm && bnd) begin
          m_commas++; m_tmo = 0;
          if (m_commas == LockCommas) begin
            m_state = 2; m_mis = 0; e_out = w; e_valid = 1; e_comma = 1;
          end
        end else if (cm) begin
          m_anchor = n; m_commas = 1; m_tmo = 0;
        end else if (bnd) begin
          m_tmo++;
          if (m_tmo == TimeoutSyms) m_state = 0;
        end
      end
      default: begin
        if (bnd) begin
          e_out = w; e_valid = 1; e_comma = cm;
        end
        if (cm && bnd) m_mis = 0;
        else if (cm) begin
          m_mis++;
          if (m_mis == MisalignLimit) begin
            m_state = 0; e_lost = 1; m_commas = 0; m_mis = 0;
          end
        end
      end
    endcase
  endtask

  task automatic check_model();
    vectors++;
    if (symbol_out !== e_out || symbol_valid !== e_valid || symbol_is_comma !== e_comma ||
        locked !== (m_state == 2) || align_state !== 2'(m_state) || lock_lost !== e_lost) begin
      miscompares++;
      $display("FAIL model[%s] cyc %0d: got out=%h v=%b c=%b lk=%b st=%0d lost=%b, want out=%h v=%b c=%b lk=%b st=%0d lost=%b",
               phase, cyc, symbol_out, symbol_valid, symbol_is_comma, locked, align_state,
               lock_lost, e_out, e_valid, e_comma, (m_state == 2), m_state, e_lost);
    end
  endtask

  task automatic tick(input logic b, input logic en);
    @(negedge clk);
    data_in = b;
    bit_en  = en;
    @(posedge clk);
    model_step(b, en);
    #1;
    if (symbol_valid) begin
      prev_valid_cyc = last_valid_cyc;
      last_valid_cyc = cyc;
    end
    check_model();
  endtask

  // Sends the low nbits of sym, MSB first, with gap disabled cycles after each bit
  task automatic send_sym(input logic [9:0] sym, input int nbits, input int gap);
    for (int i = nbits - 1; i >= 0; i--) begin
      tick(sym[i], 1'b1);
      repeat (gap) tick(1'($urandom), 1'b0);
    end
  endtask

  task automatic send_rand(input logic [9:0] sym, input int nbits);
    logic en;
    for (int i = nbits - 1; i >= 0; i--) begin
      do begin
        en = ($urandom_range(4) != 0);
        tick(en ? sym[i] : 1'($urandom), en);
      end while (!en);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    bit_en = 1'b0;
    #1;
    model_reset();
    check_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_named(input string nm, input logic ok, input string got,
                             input string want);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %s, want %s", nm, got, want);
    end
  endtask

  typedef struct {
    bit         rst;
    int         pre;
    logic [9:0] sym;
    int         rep;
    logic [1:0] st;
    logic       v;
    logic [9:0] o;
    logic       c;
    logic       l;
    string      nm;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input int pre, input logic [9:0] sym, input int rep,
                     input logic [1:0] st, input logic v, input logic [9:0] o, input logic c,
                     input logic l, input string nm);
    vec_t t;
    t.rst = r; t.pre = pre; t.sym = sym; t.rep = rep; t.st = st;
    t.v = v; t.o = o; t.c = c; t.l = l; t.nm = nm;
    tbl.push_back(t);
  endtask

  int r;

  initial begin
    model_reset();
    // rst, pre-zeros, symbol, repeats -> state, valid, out, is_comma, lock_lost
    add(1, 7,  KNeg,    1,  1, 0, 10'h000, 0, 0, "realign_first");
    add(0, 3,  KNeg,    1,  1, 0, 10'h000, 0, 0, "realign_shift");
    add(0, 0,  KNeg,    1,  1, 0, 10'h000, 0, 0, "realign_second");
    add(0, 0,  KNeg,    1,  2, 1, KNeg,    1, 0, "realign_lock");
    add(1, 7,  KNeg,    1,  1, 0, 10'h000, 0, 0, "acq_first");
    add(0, 0,  KNeg,    1,  1, 0, 10'h000, 0, 0, "acq_second");
    add(0, 0,  KNeg,    1,  2, 1, KNeg,    1, 0, "acq_lock");
    add(0, 0,  10'h2AA, 1,  2, 1, 10'h2AA, 0, 0, "data_2aa");
    add(0, 0,  KPos,    1,  2, 1, KPos,    1, 0, "data_kpos");
    add(0, 5,  KNeg,    1,  2, 0, 10'h007, 0, 0, "loss_mis1");
    add(0, 10, KNeg,    1,  2, 0, 10'h007, 0, 0, "loss_mis2");
    add(0, 10, KNeg,    1,  2, 0, 10'h007, 0, 0, "loss_mis3");
    add(0, 10, KNeg,    1,  0, 0, 10'h007, 0, 1, "loss_mis4");
    add(0, 0,  KNeg,    1,  1, 0, 10'h007, 0, 0, "relock_first");
    add(0, 0,  KNeg,    1,  1, 0, 10'h007, 0, 0, "relock_second");
    add(0, 0,  KNeg,    1,  2, 1, KNeg,    1, 0, "relock_lock");
    add(0, 5,  KNeg,    1,  2, 0, 10'h007, 0, 0, "keep_mis1");
    add(0, 10, KNeg,    1,  2, 0, 10'h007, 0, 0, "keep_mis2");
    add(0, 10, KNeg,    1,  2, 0, 10'h007, 0, 0, "keep_mis3");
    add(0, 5,  KNeg,    1,  2, 1, KNeg,    1, 0, "keep_aligned");
    add(0, 5,  KNeg,    1,  2, 0, 10'h007, 0, 0, "keep_mis1b");
    add(0, 10, KNeg,    1,  2, 0, 10'h007, 0, 0, "keep_mis2b");
    add(0, 10, KNeg,    1,  2, 0, 10'h007, 0, 0, "keep_mis3b");
    add(1, 7,  KNeg,    1,  1, 0, 10'h000, 0, 0, "tmo_comma");
    add(0, 0,  10'h2AA, 31, 1, 0, 10'h000, 0, 0, "tmo_31");
    add(0, 0,  10'h2AA, 1,  0, 0, 10'h000, 0, 0, "tmo_32");

    phase = "table";
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      send_sym(10'h000, tbl[i].pre, 0);
      repeat (tbl[i].rep) send_sym(tbl[i].sym, 10, 0);
      check_named(tbl[i].nm,
                  symbol_out === tbl[i].o && symbol_valid === tbl[i].v &&
                  symbol_is_comma === tbl[i].c && align_state === tbl[i].st &&
                  locked === (tbl[i].st == 2'd2) && lock_lost === tbl[i].l,
                  $sformatf("out=%h v=%b c=%b st=%0d lk=%b lost=%b", symbol_out, symbol_valid,
                            symbol_is_comma, align_state, locked, lock_lost),
                  $sformatf("out=%h v=%b c=%b st=%0d lk=%b lost=%b", tbl[i].o, tbl[i].v,
                            tbl[i].c, tbl[i].st, (tbl[i].st == 2'd2), tbl[i].l));
    end

    // Lock with bit_en high one cycle in three, then check valid spacing
    phase = "gaps";
    do_reset();
    send_sym(10'h000, 7, 2);
    repeat (3) send_sym(KNeg, 10, 2);
    check_named("gap_lock", locked === 1'b1 && symbol_out === KNeg,
                $sformatf("lk=%b out=%h", locked, symbol_out), "lk=1 out=0fa");
    send_sym(10'h2AA, 10, 2);
    check_named("gap_spacing", (last_valid_cyc - prev_valid_cyc) == 30,
                $sformatf("%0d cycles", last_valid_cyc - prev_valid_cyc), "30 cycles");

    // Asynchronous reset mid-symbol, off the clock edge
    send_sym(10'h2AA, 4, 0);
    #3 rst = 1'b1;
    #1;
    check_named("async_reset", symbol_out === 10'h000 && symbol_valid === 1'b0 &&
                symbol_is_comma === 1'b0 && locked === 1'b0 && align_state === 2'd0 &&
                lock_lost === 1'b0,
                $sformatf("out=%h v=%b c=%b lk=%b st=%0d lost=%b", symbol_out, symbol_valid,
                          symbol_is_comma, locked, align_state, lock_lost), "all zero");
    model_reset();
    bit_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    phase = "post_reset";
    repeat (2) send_sym(KNeg, 10, 0);
    check_named("relock_partial", align_state === 2'd1 && locked === 1'b0,
                $sformatf("st=%0d lk=%b", align_state, locked), "st=1 lk=0");
    send_sym(KNeg, 10, 0);
    check_named("relock_full", locked === 1'b1 && symbol_valid === 1'b1,
                $sformatf("lk=%b v=%b", locked, symbol_valid), "lk=1 v=1");

    // Random symbol stream: commas, data, and odd-length slips, with random bit_en
    phase = "random";
    do_reset();
    for (int u = 0; u < 500; u++) begin
      r = $urandom_range(9);
      if (r < 5) send_rand(($urandom_range(1) != 0) ? KPos : KNeg, 10);
      else if (r < 8) send_rand(10'($urandom), 10);
      else send_rand(10'($urandom), $urandom_range(9, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rx_symbol_align_ctrl.md
Name: rx_symbol_align_ctrl

Overview:
- Rx-lane symbol alignment controller. Sits beside the 10-bit serial-to-parallel stage.
- Hunts the serial bit stream for the COMMA (K28.5) pattern and establishes the 10-bit symbol boundary from it.
- Confirms alignment over several commas, then delivers boundary-aligned 10-bit symbols with a valid strobe to the 8b/10b decoder.
- Detects loss of alignment and sequences re-acquisition autonomously.

Parameters:
- LOCK_COMMAS, 3: number of consecutive boundary-aligned commas (including the first hit) required to declare lock.
- MISALIGN_LIMIT, 4: number of misaligned commas seen while LOCKED, without an intervening aligned comma, that forces loss of lock.
- TIMEOUT_SYMS, 32: number of non-comma boundary symbols tolerated in CHECK after the last aligned comma before returning to HUNT.

Ports:
- clk  in  1  Rx bit clock.
- rst  in  1  Asynchronous, active-high reset; one clock.
- data_in  in  1  Serial Rx bit; first-transmitted bit of a symbol lands in bit 9.
- bit_en  in  1  data_in is valid this cycle. When low, all state holds.
- symbol_out  out  10  Last aligned symbol; bit 9 is the first received bit.
- symbol_valid  out  1  One-cycle pulse: symbol_out is newly updated and aligned.
- symbol_is_comma  out  1  Qualifies symbol_out: it equals a K28.5 pattern.
- locked  out  1  High while in LOCKED.
- align_state  out  2  0 = HUNT, 1 = CHECK, 2 = LOCKED.
- lock_lost  out  1  One-cycle pulse on the LOCKED→HUNT transition.

Behaviour:
- Reset (asynchronous, immediate, including mid-symbol):
  - state = HUNT; window, bit_cnt (0..9), comma_cnt, misalign_cnt and timeout_cnt = 0.
  - All outputs = 0.
- Window:
  - On each edge with bit_en = 1: nxt_win = {win[8:0], data_in}; win <= nxt_win.
  - All decisions on that edge use nxt_win. Outputs are registered, so latency is 1 cycle after the edge that accepts the 10th bit.
- Comma:
  - nxt_win == 10'b0011111010 (RD−) or 10'b1100000101 (RD+).
- Boundary:
  - An accepted bit with bit_cnt == 9 is a boundary; bit_cnt wraps to 0, otherwise bit_cnt increments.
  - Aligned comma = comma at a boundary. Misaligned comma = comma at a non-boundary.
- HUNT:
  - bit_cnt is ignored.
  - Any comma: bit_cnt <= 0, comma_cnt <= 1, timeout_cnt <= 0, go to CHECK.
- CHECK:
  - Aligned comma: comma_cnt += 1 and timeout_cnt <= 0. If the new count equals LOCK_COMMAS, go to LOCKED and also emit that symbol (symbol_valid = 1, symbol_is_comma = 1).
  - Misaligned comma: realign in place — bit_cnt <= 0, comma_cnt <= 1, timeout_cnt <= 0, stay in CHECK.
  - Non-comma boundary: timeout_cnt += 1. On reaching TIMEOUT_SYMS, go to HUNT (no lock_lost pulse).
- LOCKED:
  - Every boundary: symbol_out <= nxt_win, symbol_valid = 1, symbol_is_comma = comma.
  - Aligned comma clears misalign_cnt.
  - Misaligned comma: misalign_cnt += 1, no realignment. On reaching MISALIGN_LIMIT: go to HUNT, locked falls, lock_lost = 1 for one cycle, comma_cnt and misalign_cnt cleared.
  - No symbol_valid is emitted on the edge of that transition unless it is also a boundary.
- Outside LOCKED: symbol_valid = 0 except on the CHECK→LOCKED edge. symbol_out holds its last value.
- bit_en = 0:
  - Counters and state hold; symbol_valid, lock_lost = 0.
  - Gaps of any length are transparent to alignment.
- Simultaneous events: a boundary comma is aligned, never misaligned. The timeout and lock checks are mutually exclusive by construction.
- Counter widths are sized from the parameters. Counters saturate and never wrap.

Test Plan:
- Lock acquisition: 7 zero bits, then K28.5− ×3 back-to-back with bit_en = 1 continuously.
  - align_state goes 0→1 one cycle after the 17th bit.
  - locked = 1 and symbol_valid = 1 with symbol_out = 10'h0FA and symbol_is_comma = 1, one cycle after the 37th bit.
- Data delivery: after lock, send 10'h2AA then K28.5+.
  - Two symbol_valid pulses exactly 10 cycles apart, carrying 10'h2AA (is_comma = 0) then 10'h305 (is_comma = 1).
- Realign in CHECK: after the first comma, insert 3 extra bits, then 3 commas.
  - State stays CHECK, boundary moves to the new comma.
  - Lock occurs after the 3rd comma following the shift.
- Loss of lock: in LOCKED, send 4 commas each offset by 5 bits.
  - lock_lost pulses once on the 4th; locked = 0; align_state = 0.
  - A variant with an aligned comma after 3 misaligned commas keeps lock.
- Timeout: one comma, then 32 non-comma symbols of 10'h2AA.
  - Return to HUNT on the 32nd boundary; lock_lost stays 0.
- bit_en gaps and reset: lock with bit_en toggled 1-of-3 cycles.
  - symbol_valid spacing is 30 cycles.
  - Assert rst mid-symbol: all outputs are 0 immediately, and re-lock needs 3 new commas.
